inst_loader: RTL and testbench

Boot-time loader that sits between a byte-stream source (e.g. a UART receiver) and a writable instruction memory, the write-side counterpart of the CPU's instruction fetch port. It parses a framed program image (length header, little-endian instruction words, XOR checksum), writes each word to instruction memory, and holds the MIPS core in reset until a valid image has been fully loaded.

---
 rtl/inst_loader_pkg.sv | 22 ++
 rtl/inst_loader_byte_assembler.sv | 31 +++
 rtl/inst_loader.sv | 145 ++++++++++++++
 tb/tb_inst_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package inst_loader_pkg;

    // Frame parser states: two header bytes, payload words, checksum, then a terminal state.
    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loaderState_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Word index to byte address, matching the fetch-side addressing.
    function automatic logic [31:0] wordToByteAddr(input logic [15:0] wordIdx);
        return {14'd0, wordIdx, 2'b00};
    endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects stream bytes little-endian into 32-bit words; flags the 4th byte of each word.
module byte_assembler
    import inst_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_wordValid,
    output logic [31:0] o_word
);

    logic [1:0]  r_byteIdx;
    logic [23:0] r_shift;

    // Shift each accepted byte in from the top so the first byte ends up least significant.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clear) begin
            r_byteIdx <= 2'd0;
            r_shift   <= 24'd0;
        end else if (i_valid) begin
            r_byteIdx <= r_byteIdx + 2'd1;
            r_shift   <= {i_byte, r_shift[23:8]};
        end
    end

    assign o_wordValid = i_valid && (r_byteIdx == 2'(BYTES_PER_WORD - 1));
    assign o_word      = {i_byte, r_shift};

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a length-prefixed, XOR-checked program image from a byte
// stream, writes it into instruction memory and releases the CPU once it checks out.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_adr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    loaderState_t r_state;
    loaderState_t w_nextState;

    logic        w_accept;
    logic [15:0] r_len;
    logic [15:0] w_hdrLen;
    logic        w_lenBad;
    logic [17:0] r_byteCnt;
    logic [17:0] w_payloadBytes;
    logic        w_lastByte;
    logic [7:0]  r_xor;

    logic        w_asmIn;
    logic        w_asmClear;
    logic        w_asmValid;
    logic [31:0] w_asmWord;

    logic        r_imWe;
    logic [31:0] r_imAdr;
    logic [31:0] r_imWdata;
    logic [15:0] r_wordsLoaded;

    assign w_accept       = in_valid && in_ready;
    assign w_hdrLen       = {in_data, r_len[7:0]};
    assign w_lenBad       = (w_hdrLen == 16'd0) || ({16'd0, w_hdrLen} > DEPTH_LIMIT);
    assign w_payloadBytes = {r_len, 2'b00};
    assign w_lastByte     = ((r_byteCnt + 18'd1) == w_payloadBytes);
    assign w_asmIn        = w_accept && (r_state == DATA);
    assign w_asmClear     = w_accept && (r_state == HDR0);

    byte_assembler u_assembler (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clear     (w_asmClear),
        .i_valid     (w_asmIn),
        .i_byte      (in_data),
        .o_wordValid (w_asmValid),
        .o_word      (w_asmWord)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= HDR0;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: advance only on accepted bytes; DONE and ERR hold until reset.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HDR0: if (w_accept) w_nextState = HDR1;
            HDR1: if (w_accept) w_nextState = w_lenBad ? ERR : DATA;
            DATA: if (w_accept && w_lastByte) w_nextState = CSUM;
            CSUM: if (w_accept) w_nextState = (in_data == r_xor) ? DONE : ERR;
            DONE: w_nextState = DONE;
            ERR:  w_nextState = ERR;
            default: w_nextState = ERR;
        endcase
    end

    // Status outputs decoded from state; the CPU stays in reset unless the image checked out.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_rst  = 1'b1;
        case (r_state)
            HDR0, HDR1, DATA, CSUM: in_ready = rst;
            DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ERR: error = 1'b1;
            default: error = 1'b1;
        endcase
    end

    // Header capture, payload byte count, running XOR and the registered memory write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len         <= 16'd0;
            r_byteCnt     <= 18'd0;
            r_xor         <= 8'd0;
            r_imWe        <= 1'b0;
            r_imAdr       <= 32'd0;
            r_imWdata     <= 32'd0;
            r_wordsLoaded <= 16'd0;
        end else begin
            r_imWe <= w_asmValid;
            if (w_asmValid) begin
                r_imAdr       <= wordToByteAddr(r_wordsLoaded);
                r_imWdata     <= w_asmWord;
                r_wordsLoaded <= r_wordsLoaded + 16'd1;
            end
            if (w_accept) begin
                case (r_state)
                    HDR0: begin
                        r_len[7:0] <= in_data;
                        r_byteCnt  <= 18'd0;
                        r_xor      <= 8'd0;
                    end
                    HDR1: r_len[15:8] <= in_data;
                    DATA: begin
                        r_byteCnt <= r_byteCnt + 18'd1;
                        r_xor     <= r_xor ^ in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign im_we        = r_imWe;
    assign im_adr       = r_imAdr;
    assign im_wdata     = r_imWdata;
    assign words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: a byte-queue model of the frame rules is
// compared against the DUT every cycle, plus literal checks on known frames.
module tb_inst_loader;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_adr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int nChecks = 0;
    int nErrors = 0;

    // Model state: every byte accepted since reset, payload XOR, and the expected write.
    logic [7:0]  mBytes[$];
    logic [7:0]  mXor;
    logic        mWe;
    logic [31:0] mAdr;
    logic [31:0] mWdata;
    logic        mPostReset;

    wr_t wrLog[$];

    inst_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_adr       (im_adr),
        .im_wdata     (im_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function int modelLen();
        if (mBytes.size() < 2) return 0;
        return int'({mBytes[1], mBytes[0]});
    endfunction

    function logic modelLenBad();
        return (mBytes.size() >= 2) && (modelLen() == 0 || modelLen() > DEPTH);
    endfunction

    function logic modelComplete();
        return (mBytes.size() >= 2) && !modelLenBad() && (mBytes.size() == 3 + 4 * modelLen());
    endfunction

    function logic modelCsumOk();
        return modelComplete() && (mBytes[mBytes.size() - 1] == mXor);
    endfunction

    function logic modelReady();
        return rst && !modelLenBad() && !modelComplete();
    endfunction

    function int modelWords();
        int payload;
        if (mBytes.size() < 2 || modelLenBad()) return 0;
        payload = mBytes.size() - 2;
        if (payload > 4 * modelLen()) payload = 4 * modelLen();
        return payload / 4;
    endfunction

    // Model update: record accepted bytes; a completed payload word means a write next cycle.
    always @(posedge clk) begin
        int k;
        if (!rst) begin
            mBytes.delete();
            mXor       = 8'd0;
            mWe        = 1'b0;
            mAdr       = 32'd0;
            mWdata     = 32'd0;
            mPostReset = 1'b1;
        end else begin
            mPostReset = 1'b0;
            mWe        = 1'b0;
            if (in_valid && modelReady()) begin
                mBytes.push_back(in_data);
                k = mBytes.size() - 1;
                if (k >= 2 && !modelLenBad() && k < 2 + 4 * modelLen()) begin
                    mXor ^= in_data;
                    if ((k - 2) % 4 == 3) begin
                        mWe    = 1'b1;
                        mAdr   = 32'(4 * ((k - 2) / 4));
                        mWdata = {mBytes[k], mBytes[k-1], mBytes[k-2], mBytes[k-3]};
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, and a log of the writes the DUT issued.
    always @(negedge clk) begin
        checkOutput("in_ready", 32'(in_ready), 32'(modelReady()));
        checkOutput("im_we", 32'(im_we), 32'(mWe));
        if (mWe || mPostReset) begin
            checkOutput("im_adr", im_adr, mAdr);
            checkOutput("im_wdata", im_wdata, mWdata);
        end
        checkOutput("done", 32'(done), 32'(modelCsumOk()));
        checkOutput("cpu_rst", 32'(cpu_rst), 32'(!modelCsumOk()));
        checkOutput("error", 32'(error), 32'(modelLenBad() || (modelComplete() && !modelCsumOk())));
        checkOutput("words_loaded", 32'(words_loaded), 32'(modelWords()));
        if (!rst) begin
            wrLog.delete();
        end else if (im_we === 1'b1) begin
            wrLog.push_back('{adr: im_adr, data: im_wdata});
        end
    end

    task automatic doReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Drive a frame with random idle gaps; stop early once the loader should stop accepting.
    task automatic applyStimulus(input logic [7:0] frame[$], input int gapMax, input int stopAfter);
        int gap;
        for (int i = 0; i < frame.size(); i++) begin
            if (stopAfter >= 0 && i >= stopAfter) break;
            gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk);
                #2;
            end
            if (!modelReady()) break;
            in_valid = 1'b1;
            in_data  = frame[i];
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
    endtask

    task automatic buildFrame(input int len, input logic corrupt, output logic [7:0] f[$]);
        logic [7:0] x;
        logic [7:0] b;
        f.delete();
        f.push_back(len[7:0]);
        f.push_back(len[15:8]);
        x = 8'd0;
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom);
            x ^= b;
            f.push_back(b);
        end
        if (corrupt) x ^= 8'($urandom_range(255, 1));
        f.push_back(x);
    endtask

    // Writes expected straight from the frame bytes: word w at 4*w, little-endian.
    task automatic checkLog(input logic [7:0] f[$]);
        int len;
        logic [31:0] w;
        len = int'({f[1], f[0]});
        checkOutput("log_size", 32'(wrLog.size()), 32'(len));
        for (int i = 0; i < len && i < wrLog.size(); i++) begin
            w = {f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]};
            checkOutput("log_adr", wrLog[i].adr, 32'(4 * i));
            checkOutput("log_data", wrLog[i].data, w);
        end
    endtask

    initial begin
        logic [7:0] f[$];
        logic       corrupt;
        int         len;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("reset_words", 32'(words_loaded), 32'd0);
        checkOutput("reset_adr", im_adr, 32'd0);
        @(posedge clk);
        #2;

        // Two-word image with a matching checksum (XOR of the payload is 0x21).
        f = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h21};
        applyStimulus(f, 0, -1);
        settle();
        checkOutput("good_log_size", 32'(wrLog.size()), 32'd2);
        if (wrLog.size() == 2) begin
            checkOutput("good_adr0", wrLog[0].adr, 32'h0000_0000);
            checkOutput("good_data0", wrLog[0].data, 32'h0100_0820);
            checkOutput("good_adr1", wrLog[1].adr, 32'h0000_0004);
            checkOutput("good_data1", wrLog[1].data, 32'h0800_0000);
        end
        checkOutput("good_done", 32'(done), 32'd1);
        checkOutput("good_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("good_words", 32'(words_loaded), 32'd2);
        doReset();

        // Same image, wrong checksum.
        f[10] = 8'hFF;
        applyStimulus(f, 0, -1);
        settle();
        checkOutput("bad_log_size", 32'(wrLog.size()), 32'd2);
        checkOutput("bad_error", 32'(error), 32'd1);
        checkOutput("bad_done", 32'(done), 32'd0);
        checkOutput("bad_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("bad_in_ready", 32'(in_ready), 32'd0);
        doReset();

        // Zero length and one-past-capacity length.
        f = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        applyStimulus(f, 0, -1);
        settle();
        checkOutput("len0_error", 32'(error), 32'd1);
        checkOutput("len0_writes", 32'(wrLog.size()), 32'd0);
        doReset();
        len = DEPTH + 1;
        f = '{len[7:0], len[15:8], 8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(f, 2, -1);
        settle();
        checkOutput("lenbig_error", 32'(error), 32'd1);
        checkOutput("lenbig_writes", 32'(wrLog.size()), 32'd0);
        checkOutput("lenbig_words", 32'(words_loaded), 32'd0);
        doReset();

        // Random images with random gaps, some with corrupted checksums.
        for (int t = 0; t < 10; t++) begin
            corrupt = ($urandom_range(2, 0) == 0);
            buildFrame(int'($urandom_range(10, 1)), corrupt, f);
            applyStimulus(f, (t % 2 == 0) ? 3 : 0, -1);
            settle();
            checkLog(f);
            checkOutput("rand_done", 32'(done), 32'(!corrupt));
            checkOutput("rand_error", 32'(error), 32'(corrupt));
            doReset();
        end

        // Reset after six payload bytes, then a clean one-word image.
        buildFrame(2, 1'b0, f);
        applyStimulus(f, 0, 8);
        doReset();
        f = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        applyStimulus(f, 1, -1);
        settle();
        checkOutput("rst_log_size", 32'(wrLog.size()), 32'd1);
        if (wrLog.size() == 1) begin
            checkOutput("rst_adr", wrLog[0].adr, 32'd0);
            checkOutput("rst_data", wrLog[0].data, 32'h1234_5678);
        end
        checkOutput("rst_words", 32'(words_loaded), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd1);
        doReset();

        // Full-capacity image, back to back.
        buildFrame(DEPTH, 1'b0, f);
        applyStimulus(f, 0, -1);
        settle();
        checkOutput("full_log_size", 32'(wrLog.size()), 32'(DEPTH));
        if (wrLog.size() > 0)
            checkOutput("full_last_adr", wrLog[wrLog.size() - 1].adr, 32'(4 * (DEPTH - 1)));
        checkOutput("full_words", 32'(words_loaded), 32'(DEPTH));
        checkOutput("full_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
